// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - FIR output requantizer (Q4.18 -> Q2.10) with elastic FIFO
// Stage 1 rounds half-up and saturates; stage 2 buffers samples for a valid/ready consumer.
module fir_out_requant #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 12,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat_flag,
  input  logic                     sat_clr,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = IN_W - SHIFT + 1;

  logic [RW-1:0]       w_round;
  logic [RW-OUT_W:0]   w_hi;
  logic                w_sat;
  logic [OUT_W-1:0]    w_q;
  logic                w_unused;

  // One extra sign bit so the rounding increment can never wrap.
  assign w_round  = {in_data[IN_W-1], in_data[IN_W-1:SHIFT]} + {{(RW-1){1'b0}}, in_data[SHIFT-1]};
  assign w_hi     = w_round[RW-1:OUT_W-1];
  assign w_sat    = ~((&w_hi) | ~(|w_hi));
  assign w_q      = w_sat ? (w_round[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                          : w_round[OUT_W-1:0];
  assign w_unused = ^in_data[SHIFT-2:0];

  logic               r_s_valid;
  logic [OUT_W-1:0]   r_s_data;
  logic               r_sat_flag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s_valid  <= 1'b0;
      r_s_data   <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      r_s_valid <= in_valid;
      if (in_valid) r_s_data <= w_q;
      if (in_valid && w_sat) r_sat_flag <= 1'b1;
      else if (sat_clr)      r_sat_flag <= 1'b0;
    end
  end

  logic [OUT_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;
  logic [7:0]         r_drop_cnt;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = ~w_empty & out_ready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_wr    = r_s_valid & (~w_full | w_pop);
  assign w_drop  = r_s_valid & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_s_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = ~w_empty;
  assign level     = r_level;
  assign sat_flag  = r_sat_flag;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fir_out_requant.sv
// tb/tb_fir_out_requant.sv - self-checking bench for fir_out_requant
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        rstn;
  logic [21:0] in_data;
  logic        in_valid;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat_flag;
  logic        sat_clr;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  fir_out_requant dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_flag (sat_flag),
    .sat_clr  (sat_clr),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] mq[$];
  logic        m_sv;
  logic [11:0] m_sd;
  int          m_drop;
  logic        m_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round half up = floor(x/256 + 1/2), then clamp to the Q2.10 range.
  function automatic logic [12:0] model_q(input logic [21:0] x);
    int xi;
    int r;
    xi = x[21] ? int'(x) - (1 << 22) : int'(x);
    r  = (xi + 128) >>> 8;
    if (r > 2047)  return {1'b1, 12'h7FF};
    if (r < -2048) return {1'b1, 12'h800};
    return {1'b0, r[11:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sv   = 1'b0;
    m_sd   = '0;
    m_drop = 0;
    m_sat  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, level, mq.size());
    chk({tag, ".valid"}, out_valid, mq.size() > 0);
    if (mq.size() > 0) chk({tag, ".data"}, out_data, mq[0]);
    chk({tag, ".drop"}, drop_cnt, m_drop);
    chk({tag, ".sat"}, sat_flag, m_sat);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".data"},  out_data,  0);
    chk({tag, ".valid"}, out_valid, 0);
    chk({tag, ".sat"},   sat_flag,  0);
    chk({tag, ".drop"},  drop_cnt,  0);
    chk({tag, ".level"}, level,     0);
  endtask

  task automatic cyc(input logic v, input logic [21:0] d, input logic rdy, input logic clr);
    logic        pop;
    logic [12:0] q;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    sat_clr   = clr;
    @(posedge clk);
    pop = (mq.size() > 0) && rdy;
    if (pop) mq.delete(0);
    if (m_sv) begin
      if (mq.size() < 4) mq.push_back(m_sd);
      else if (m_drop < 255) m_drop++;
    end
    q    = model_q(d);
    m_sv = v;
    if (v) m_sd = q[11:0];
    if (v && q[12]) m_sat = 1'b1;
    else if (clr)   m_sat = 1'b0;
    #1;
    check_all("model");
    in_valid = 1'b0;
    sat_clr  = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [21:0] d, input logic [11:0] exp);
    cyc(1'b1, d, 1'b1, 1'b0);
    chk({tag, ".notyet"}, out_valid, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".data"}, out_data, exp);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk({tag, ".onecycle"}, out_valid, 0);
  endtask

  initial begin
    logic [11:0] last;
    int          exp_next;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;
    model_reset();
    #3;
    check_reset_vals("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    send_one("round_1p0", 22'h000100, 12'h001);
    send_one("round_1p5", 22'h000180, 12'h002);
    send_one("round_m1p5", 22'h3FFE80, 12'hFFF);

    send_one("sat_pos", 22'h1FFFFF, 12'h7FF);
    chk("sat_pos.flag", sat_flag, 1);
    send_one("sat_neg", 22'h200000, 12'h800);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("sat_clr", sat_flag, 0);
    cyc(1'b1, 22'h1FFFFF, 1'b1, 1'b1);
    chk("sat_set_wins", sat_flag, 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    for (int i = 1; i <= 5; i++) cyc(1'b1, 22'(i << 8), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("ovf.level", level, 4);
    chk("ovf.drop", drop_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf.order", out_data, i);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("ovf.empty", level, 0);

    for (int i = 1; i <= 4; i++) cyc(1'b1, 22'(i << 8), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 22'h000A00, 1'b0, 1'b0);
    chk("pp_full.pre", level, 4);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pp_full.level", level, 4);
    chk("pp_full.drop", drop_cnt, 1);
    last = '0;
    for (int i = 0; i < 6 && out_valid; i++) begin
      last = out_data;
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("pp_full.last", last, 12'h00A);
    chk("pp_full.drained", level, 0);

    exp_next = 1;
    for (int i = 1; i <= 12; i++) begin
      cyc(i <= 10, 22'(i << 8), 1'b1, 1'b0);
      if (out_valid) begin
        chk("b2b.order", out_data, exp_next);
        exp_next++;
      end
    end
    chk("b2b.count", exp_next, 11);
    chk("b2b.drop", drop_cnt, 1);

    for (int i = 1; i <= 3; i++) cyc(1'b1, 22'(i << 8), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst_mid.pre", level, 3);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    send_one("rst_mid.after", 22'h000300, 12'h003);

    for (int i = 0; i < 400; i++) begin
      logic [21:0] d;
      case ($urandom_range(0, 3))
        0:       d = 22'($urandom);
        1:       d = 22'($urandom_range(0, 4095)) - 22'd2048;
        2:       d = $urandom_range(0, 1) ? 22'h1FFFFF : 22'h200000;
        default: d = 22'($urandom_range(0, 511)) | 22'h000080;
      endcase
      cyc($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
